mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 2: consecutive lost fetch arbitrations before fetch wins over load/store.
REQ-002 SHALL have parameter MEM_BYTES, default 1024: byte size of attached RAM; higher addresses are out of range.
REQ-003 SHALL have port clock  in  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port if_req_valid  in  1  fetch request present.
REQ-006 SHALL have port if_req_ready  out  1  fetch request accepted this cycle.
REQ-007 SHALL have port if_req_addr  in  XLEN  fetch byte address.
REQ-008 SHALL have port if_resp_valid  out  1  fetch response present.
REQ-009 SHALL have port if_resp_data  out  XLEN  fetched word.
REQ-010 SHALL have port if_resp_err  out  1  fetch fault.
REQ-011 SHALL have port ls_req_valid  in  1  load/store request present.
REQ-012 SHALL have port ls_req_ready  out  1  load/store request accepted this cycle.
REQ-013 SHALL have port ls_req_addr  in  XLEN  load/store byte address.
REQ-014 SHALL have port ls_req_write  in  1  1 = store, 0 = load.
REQ-015 SHALL have port ls_req_wwidth  in  write_width_t  access width for load and store.
REQ-016 SHALL have port ls_req_wdata  in  XLEN  store data, right-aligned.
REQ-017 SHALL have port ls_resp_valid  out  1  load/store response present.
REQ-018 SHALL have port ls_resp_data  out  XLEN  load data, zero-extended.
REQ-019 SHALL have port ls_resp_err  out  1  load/store fault.
REQ-020 SHALL have ports ram_addr  out  XLEN, ram_wwidth  out  write_width_t, ram_wenable  out  1, ram_wdata  out  XLEN: RAM drive.
REQ-021 SHALL have port ram_rdata  in  XLEN  RAM read data, valid the cycle after address, already offset-shifted.

Function
REQ-022 SHALL accept at most one request per cycle; accepted means valid && ready; ready is combinational from valids and starve counter, never depends on ready.
REQ-023 SHALL grant the only valid requester when exactly one is valid.
REQ-024 SHALL grant load/store when both are valid, unless starve counter == STARVE_LIMIT, then grant fetch.
REQ-025 Starve counter SHALL increment (saturating at STARVE_LIMIT) each cycle if_req_valid is high and fetch is not granted; SHALL clear when fetch is granted or if_req_valid is low.
REQ-026 Fetch SHALL be treated as a word read; ram_wenable SHALL be 0 for fetches and loads.
REQ-027 Fault SHALL be: word with addr[1:0] != 0, halfword with addr[0] = 1, or addr >= MEM_BYTES.
REQ-028 Granted store without fault SHALL drive ram_wenable = 1, ram_addr/ram_wwidth/ram_wdata from ls request in the grant cycle.
REQ-029 Faulting request SHALL still be accepted, SHALL NOT assert ram_wenable, and SHALL respond with err = 1, data = 0.
REQ-030 With no grant, ram_wenable SHALL be 0 and ram_addr 0.
REQ-031 Every accepted request granted in cycle N SHALL produce exactly one resp_valid pulse to its owner in cycle N+1; no response back-pressure.
REQ-032 Load response data SHALL be ram_rdata masked to width: byte -> [7:0], halfword -> [15:0], word unchanged; fetch data unmasked.
REQ-033 Store response SHALL carry data = 0, err = 0 unless faulted.
REQ-034 Back-to-back grants SHALL sustain one request per cycle; a read granted the cycle after a store to the same word SHALL return the new data.
REQ-035 resp_data/resp_err SHALL be 0 whenever the matching resp_valid is 0.

Reset
REQ-036 While reset_n = 0: all resp_valid/resp_data/resp_err 0, ram_wenable 0, readies 0, starve counter 0; a pending response is discarded and never emitted after release.

Verification
REQ-037 Store word 0x87654321 @0x10, then fetch 0x10 -> ls_resp_valid pulse, then if_resp_valid next cycle after fetch accept with 0x87654321.
REQ-038 Both valid continuously, STARVE_LIMIT = 2 -> grant sequence LS, LS, IF repeating; one response per cycle to correct owner.
REQ-039 Store byte 0xBA @0x11, load word 0x10 -> 0x8765BA21; load halfword 0x12 -> 0x00008765; load byte 0x11 -> 0x000000BA.
REQ-040 Load word 0x12 and store halfword 0x13 -> ls_resp_err = 1, data 0; ram_wenable never 1; later word load 0x10 unchanged.
REQ-041 Fetch 0x400 (MEM_BYTES = 1024) and fetch 0x02 -> if_resp_err = 1 each.
REQ-042 reset_n low the cycle after a load accept -> no ls_resp_valid after release; all outputs 0 during reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: an instruction-fetch port and a load/store port share one RAM.
// Load/store has priority unless fetch has already lost STARVE_LIMIT arbitrations in a row.

package mem_arbiter_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        WW_BYTE = 2'd0,
        WW_HALF = 2'd1,
        WW_WORD = 2'd2
    } write_width_t;
endpackage

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 2,
    parameter int MEM_BYTES    = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_req_addr,
    output logic              if_resp_valid,
    output logic [XLEN-1:0]   if_resp_data,
    output logic              if_resp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [XLEN-1:0]   ls_req_addr,
    input  logic              ls_req_write,
    input  write_width_t      ls_req_wwidth,
    input  logic [XLEN-1:0]   ls_req_wdata,
    output logic              ls_resp_valid,
    output logic [XLEN-1:0]   ls_resp_data,
    output logic              ls_resp_err,
    output logic [XLEN-1:0]   ram_addr,
    output write_width_t      ram_wwidth,
    output logic              ram_wenable,
    output logic [XLEN-1:0]   ram_wdata,
    input  logic [XLEN-1:0]   ram_rdata
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } grant_t;

    // An unknown width encoding is reported as a fault rather than guessed at.
    function automatic logic access_fault(input logic [XLEN-1:0] addr, input write_width_t width);
        logic f;
        case (width)
            WW_BYTE: f = 1'b0;
            WW_HALF: f = addr[0];
            WW_WORD: f = |addr[1:0];
            default: f = 1'b1;
        endcase
        if (addr >= XLEN'(MEM_BYTES)) begin
            f = 1'b1;
        end
        return f;
    endfunction

    function automatic logic [XLEN-1:0] width_mask(input logic [XLEN-1:0] data, input write_width_t width);
        logic [XLEN-1:0] m;
        case (width)
            WW_BYTE: m = {{(XLEN-8){1'b0}}, data[7:0]};
            WW_HALF: m = {{(XLEN-16){1'b0}}, data[15:0]};
            WW_WORD: m = data;
            default: m = {XLEN{1'b0}};
        endcase
        return m;
    endfunction

    grant_t          grant_s;
    logic [CW-1:0]   starve_r;
    logic [XLEN-1:0] req_addr_s;
    write_width_t    req_width_s;
    logic            req_write_s;
    logic            req_fault_s;

    logic            if_rv_r;
    logic            if_err_r;
    logic            ls_rv_r;
    logic            ls_err_r;
    logic            ls_load_r;
    write_width_t    ls_width_r;

    // Arbitration; nothing is granted while reset is held.
    always_comb begin
        grant_s = GNT_NONE;
        if (!reset_n) begin
            grant_s = GNT_NONE;
        end else if (if_req_valid && ls_req_valid) begin
            grant_s = (starve_r == STARVE_MAX) ? GNT_IF : GNT_LS;
        end else if (if_req_valid) begin
            grant_s = GNT_IF;
        end else if (ls_req_valid) begin
            grant_s = GNT_LS;
        end else begin
            grant_s = GNT_NONE;
        end
    end

    // Select the granted request and classify it.
    always_comb begin
        req_addr_s  = {XLEN{1'b0}};
        req_width_s = WW_BYTE;
        req_write_s = 1'b0;
        case (grant_s)
            GNT_IF: begin
                req_addr_s  = if_req_addr;
                req_width_s = WW_WORD;
                req_write_s = 1'b0;
            end
            GNT_LS: begin
                req_addr_s  = ls_req_addr;
                req_width_s = ls_req_wwidth;
                req_write_s = ls_req_write;
            end
            default: begin
                req_addr_s  = {XLEN{1'b0}};
                req_width_s = WW_BYTE;
                req_write_s = 1'b0;
            end
        endcase
        req_fault_s = (grant_s != GNT_NONE) && access_fault(req_addr_s, req_width_s);
    end

    // Request handshakes and RAM drive for the grant cycle.
    always_comb begin
        if_req_ready = (grant_s == GNT_IF);
        ls_req_ready = (grant_s == GNT_LS);
        ram_addr     = req_addr_s;
        ram_wwidth   = req_width_s;
        ram_wenable  = 1'b0;
        ram_wdata    = {XLEN{1'b0}};
        if ((grant_s == GNT_LS) && req_write_s && !req_fault_s) begin
            ram_wenable = 1'b1;
            ram_wdata   = ls_req_wdata;
        end else begin
            ram_wenable = 1'b0;
            ram_wdata   = {XLEN{1'b0}};
        end
    end

    // Count consecutive fetch arbitration losses, saturating at the limit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            starve_r <= {CW{1'b0}};
        end else if (!if_req_valid || (grant_s == GNT_IF)) begin
            starve_r <= {CW{1'b0}};
        end else if (starve_r != STARVE_MAX) begin
            starve_r <= starve_r + CW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Response bookkeeping for the cycle after the grant; reset drops anything pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_rv_r    <= 1'b0;
            if_err_r   <= 1'b0;
            ls_rv_r    <= 1'b0;
            ls_err_r   <= 1'b0;
            ls_load_r  <= 1'b0;
            ls_width_r <= WW_BYTE;
        end else begin
            if_rv_r    <= (grant_s == GNT_IF);
            if_err_r   <= (grant_s == GNT_IF) && req_fault_s;
            ls_rv_r    <= (grant_s == GNT_LS);
            ls_err_r   <= (grant_s == GNT_LS) && req_fault_s;
            ls_load_r  <= (grant_s == GNT_LS) && !req_write_s && !req_fault_s;
            ls_width_r <= (grant_s == GNT_LS) ? req_width_s : WW_BYTE;
        end
    end

    // Read data arrives from the RAM this cycle, so only the qualifiers are registered.
    always_comb begin
        if_resp_valid = if_rv_r;
        if_resp_err   = if_err_r;
        ls_resp_valid = ls_rv_r;
        ls_resp_err   = ls_err_r;
        if (if_rv_r && !if_err_r) begin
            if_resp_data = ram_rdata;
        end else begin
            if_resp_data = {XLEN{1'b0}};
        end
        if (ls_load_r) begin
            ls_resp_data = width_mask(ram_rdata, ls_width_r);
        end else begin
            ls_resp_data = {XLEN{1'b0}};
        end
    end

endmodule
